// File: rtl/threshold_debouncer.sv
// Hysteresis plus consecutive-sample debounce on comparator high/low flags.
// Produces a registered level, rise/fall pulses, a saturating rise counter and a sticky error flag.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_LOW     | stable low, waiting for a sample above the high threshold
// ST_RISING  | counting consecutive high samples toward DEBOUNCE
// ST_HIGH    | stable high, waiting for a sample below the low threshold
// ST_FALLING | counting consecutive low samples toward DEBOUNCE
module threshold_debouncer #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             hi_gt_i,
    input  logic             lo_lt_i,
    input  logic             clear_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] event_cnt_o,
    output logic             err_o
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             accept;
    logic             conflict;
    logic             cnt_full;

    // A conflict sample is treated like a gap by the FSM; it only raises err_o.
    assign conflict = valid_i & hi_gt_i & lo_lt_i;
    assign accept   = valid_i & ~(hi_gt_i & lo_lt_i);
    assign run_inc  = run + RUN_W'(1);
    assign cnt_full = &event_cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_LOW;
            run         <= '0;
            level_o     <= 1'b0;
            rise_o      <= 1'b0;
            fall_o      <= 1'b0;
            event_cnt_o <= '0;
            err_o       <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;

            if (accept) begin
                case (state)
                    ST_LOW: begin
                        if (hi_gt_i) begin
                            if (DEBOUNCE == 1) begin
                                state   <= ST_HIGH;
                                level_o <= 1'b1;
                                rise_o  <= 1'b1;
                                if (!cnt_full) event_cnt_o <= event_cnt_o + CNT_W'(1);
                            end else begin
                                state <= ST_RISING;
                                run   <= RUN_W'(1);
                            end
                        end
                    end
                    ST_RISING: begin
                        if (hi_gt_i) begin
                            if (run_inc == RUN_DONE) begin
                                state   <= ST_HIGH;
                                run     <= '0;
                                level_o <= 1'b1;
                                rise_o  <= 1'b1;
                                if (!cnt_full) event_cnt_o <= event_cnt_o + CNT_W'(1);
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            state <= ST_LOW;
                            run   <= '0;
                        end
                    end
                    ST_HIGH: begin
                        if (lo_lt_i) begin
                            if (DEBOUNCE == 1) begin
                                state   <= ST_LOW;
                                level_o <= 1'b0;
                                fall_o  <= 1'b1;
                            end else begin
                                state <= ST_FALLING;
                                run   <= RUN_W'(1);
                            end
                        end
                    end
                    ST_FALLING: begin
                        if (lo_lt_i) begin
                            if (run_inc == RUN_DONE) begin
                                state   <= ST_LOW;
                                run     <= '0;
                                level_o <= 1'b0;
                                fall_o  <= 1'b1;
                            end else begin
                                run <= run_inc;
                            end
                        end else begin
                            state <= ST_HIGH;
                            run   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_LOW;
                        run   <= '0;
                    end
                endcase
            end

            if (conflict) err_o <= 1'b1;

            // Clear overrides any increment or error set in the same cycle.
            if (clear_i) begin
                event_cnt_o <= '0;
                err_o       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_threshold_debouncer.sv
// Scoreboard bench for threshold_debouncer (DEBOUNCE=3, CNT_W=4): a behavioural model
// pushes expected outputs per driven cycle; directed checks cover the key scenarios.
module tb_threshold_debouncer;

    localparam int D = 3;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          hi_gt_i = 1'b0;
    logic          lo_lt_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          level_o;
    logic          rise_o;
    logic          fall_o;
    logic [CW-1:0] event_cnt_o;
    logic          err_o;

    threshold_debouncer #(.DEBOUNCE(D), .CNT_W(CW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .hi_gt_i    (hi_gt_i),
        .lo_lt_i    (lo_lt_i),
        .clear_i    (clear_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .event_cnt_o(event_cnt_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    // model: 0 LOW, 1 RISING, 2 HIGH, 3 FALLING
    int            m_state = 0;
    int            m_run = 0;
    logic          m_level = 1'b0;
    logic          m_rise = 1'b0;
    logic          m_fall = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic          m_err = 1'b0;

    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_cycle(input logic v, input logic h, input logic l, input logic c,
                               input logic r);
        logic acc;
        if (r) begin
            m_state = 0; m_run = 0; m_level = 0; m_rise = 0; m_fall = 0; m_cnt = '0; m_err = 0;
            return;
        end
        acc = v && !(h && l);
        m_rise = 0;
        m_fall = 0;
        if (acc) begin
            case (m_state)
                0: if (h) begin m_state = 1; m_run = 1; end
                1: if (h) begin
                       m_run++;
                       if (m_run == D) begin m_state = 2; m_run = 0; m_rise = 1; end
                   end else begin m_state = 0; m_run = 0; end
                2: if (l) begin m_state = 3; m_run = 1; end
                default: if (l) begin
                       m_run++;
                       if (m_run == D) begin m_state = 0; m_run = 0; m_fall = 1; end
                   end else begin m_state = 2; m_run = 0; end
            endcase
        end
        if (m_rise) begin
            m_level = 1;
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        if (m_fall) m_level = 0;
        if (v && h && l) m_err = 1;
        if (c) begin m_cnt = '0; m_err = 0; end
    endtask

    task automatic step(input logic v, input logic h, input logic l, input logic c,
                        input logic r);
        logic [7:0] got;
        @(negedge clk_i);
        rst_i = r; valid_i = v; hi_gt_i = h; lo_lt_i = l; clear_i = c;
        model_cycle(v, h, l, c, r);
        exp_q.push_back({m_level, m_rise, m_fall, m_cnt, m_err});
        @(posedge clk_i);
        #1;
        got = {level_o, rise_o, fall_o, event_cnt_o, err_o};
        check_val("cycle", 32'(got), 32'(exp_q.pop_front()));
        rise_seen += int'(rise_o);
        fall_seen += int'(fall_o);
    endtask

    task automatic hi(); step(1, 1, 0, 0, 0); endtask
    task automatic lo(); step(1, 0, 1, 0, 0); endtask
    task automatic band(); step(1, 0, 0, 0, 0); endtask
    task automatic idle(); step(0, 0, 0, 0, 0); endtask

    initial begin
        // reset with arbitrary inputs
        step(1, 1, 1, 1, 1);
        step(1, 1, 0, 0, 1);
        check_val("rst_level", 32'(level_o), 0);
        check_val("rst_pulses", 32'({rise_o, fall_o}), 0);
        check_val("rst_cnt", 32'(event_cnt_o), 0);
        check_val("rst_err", 32'(err_o), 0);

        hi(); hi();
        check_val("first_no_early_rise", 32'(rise_o), 0);
        hi();
        check_val("first_rise", 32'(rise_o), 1);
        check_val("first_level", 32'(level_o), 1);
        check_val("first_cnt", 32'(event_cnt_o), 1);
        idle();
        check_val("rise_single_pulse", 32'(rise_o), 0);

        // aborted rise
        lo(); lo(); lo();
        check_val("fall_to_low", 32'(level_o), 0);
        rise_seen = 0;
        hi(); hi(); band(); hi(); hi();
        check_val("abort_no_rise", 32'(rise_seen), 0);
        check_val("abort_level", 32'(level_o), 0);
        hi();
        check_val("abort_then_rise", 32'(rise_o), 1);
        check_val("abort_cnt", 32'(event_cnt_o), 2);

        // gaps between qualifying samples
        lo(); lo(); lo();
        rise_seen = 0;
        repeat (5) idle();
        hi();
        idle();
        hi();
        repeat (3) idle();
        check_val("gap_no_early_rise", 32'(rise_seen), 0);
        hi();
        check_val("gap_rise", 32'(rise_o), 1);
        check_val("gap_cnt", 32'(event_cnt_o), 3);

        // fall with a band sample aborting the first attempt
        fall_seen = 0;
        lo(); lo(); band(); lo(); lo();
        check_val("fall_none_early", 32'(fall_seen), 0);
        check_val("fall_level_hold", 32'(level_o), 1);
        lo();
        check_val("fall_pulse", 32'(fall_o), 1);
        check_val("fall_level", 32'(level_o), 0);
        check_val("fall_cnt_unchanged", 32'(event_cnt_o), 3);
        check_val("fall_count", 32'(fall_seen), 1);

        // saturation
        for (int i = 0; i < 16; i++) begin
            hi(); hi(); hi();
            lo(); lo(); lo();
        end
        check_val("sat_cnt", 32'(event_cnt_o), 15);

        // clear coinciding with a rise
        hi(); hi();
        step(1, 1, 0, 1, 0);
        check_val("clr_rise_pulse", 32'(rise_o), 1);
        check_val("clr_rise_cnt", 32'(event_cnt_o), 0);
        check_val("clr_rise_level", 32'(level_o), 1);

        // conflict during RISING with run=2
        lo(); lo(); lo();
        hi(); hi();
        step(1, 1, 1, 0, 0);
        check_val("conf_err", 32'(err_o), 1);
        check_val("conf_level", 32'(level_o), 0);
        check_val("conf_no_rise", 32'(rise_o), 0);
        hi();
        check_val("conf_then_rise", 32'(rise_o), 1);
        check_val("conf_err_sticky", 32'(err_o), 1);
        check_val("conf_cnt", 32'(event_cnt_o), 1);
        step(0, 0, 0, 1, 0);
        check_val("conf_clear_err", 32'(err_o), 0);
        check_val("conf_clear_cnt", 32'(event_cnt_o), 0);

        // reset mid-run
        lo(); lo();
        step(0, 0, 0, 0, 1);
        check_val("midrst_level", 32'(level_o), 0);
        hi(); hi();
        check_val("midrst_no_rise", 32'(rise_o), 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/threshold_debouncer.md
# threshold_debouncer

- Sits directly downstream of `comparator`, which runs two instances: sample vs high threshold (`gt_o`) and sample vs low threshold (`lt_o`).
- Consumes those flags per valid sample and applies hysteresis plus a consecutive-sample debounce.
- Produces a clean registered level, single-cycle rise/fall event pulses, and a saturating rise-event counter for downstream control and status logic.

## Interface
- `DEBOUNCE`, default 4: consecutive qualifying valid samples required to change level. Legal range 1..255.
- `CNT_W`, default 8: width of the rise-event counter.
- `clk_i` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `valid_i` input, 1 bit: the flags this cycle belong to a new sample.
- `hi_gt_i` input, 1 bit: sample > high threshold (`gt_o` of the high comparator).
- `lo_lt_i` input, 1 bit: sample < low threshold (`lt_o` of the low comparator).
- `clear_i` input, 1 bit: synchronous clear of `event_cnt_o` and `err_o` only.
- `level_o` output, 1 bit: debounced level.
- `rise_o` output, 1 bit: one-cycle pulse on a low-to-high transition.
- `fall_o` output, 1 bit: one-cycle pulse on a high-to-low transition.
- `event_cnt_o` output, `CNT_W` bits: number of rise events, saturating.
- `err_o` output, 1 bit: sticky; a valid sample arrived with `hi_gt_i` and `lo_lt_i` both set.

## Operation
- **FSM states:** LOW, RISING, HIGH, FALLING. Internal run counter `run`, width $clog2(DEBOUNCE+1).
- **Accepted sample:** `valid_i`=1 and not (`hi_gt_i`=1 and `lo_lt_i`=1).
- **Conflict sample:** `valid_i`=1 with both flags set.
  - Sets `err_o`.
  - Otherwise treated exactly like `valid_i`=0: state and `run` hold.
- **Non-valid cycles** (`valid_i`=0): state and `run` hold. Gaps do not break a run.
- **LOW:**
  - Accepted sample with `hi_gt_i`=1:
    - If DEBOUNCE=1: go to HIGH and issue a rise.
    - Otherwise: go to RISING with `run`=1.
  - Any other accepted sample: stay in LOW.
- **RISING:**
  - Accepted sample with `hi_gt_i`=1: `run`+1. When `run`+1 = DEBOUNCE, go to HIGH, issue a rise, `run`=0.
  - Accepted sample with `hi_gt_i`=0: go back to LOW, `run`=0.
- **HIGH:** mirror of LOW, using `lo_lt_i`; goes to FALLING (or straight to LOW with a fall when DEBOUNCE=1).
- **FALLING:**
  - Accepted sample with `lo_lt_i`=1: count as in RISING. Reaching DEBOUNCE goes to LOW and issues a fall.
  - Accepted sample with `lo_lt_i`=0: go back to HIGH, `run`=0.
- **Hysteresis band:** a sample with both flags 0 aborts a pending transition. It never changes a stable state.
- **`level_o`** = 1 in HIGH and FALLING; 0 in LOW and RISING.
- **Rise:** `event_cnt_o` increments by 1 and saturates at 2^CNT_W-1. No wrap.
- **`clear_i`:** forces `event_cnt_o`=0 and `err_o`=0 and wins over a simultaneous rise increment or conflict sample. It does not affect the FSM, `run`, `level_o` or the pulses.

## Timing
- All outputs are registered.
- **Reset values:** `level_o`=0, `rise_o`=0, `fall_o`=0, `event_cnt_o`=0, `err_o`=0. State LOW, `run`=0.
- **Reset mid-run:** `rst_i` asserted during RISING or FALLING discards the run. Outputs reach their reset values the cycle after the reset edge.
- **Latency:** the DEBOUNCE-th qualifying sample is presented in cycle n. In cycle n+1:
  - `rise_o`/`fall_o` is high for exactly one cycle;
  - `level_o` holds its new value;
  - `event_cnt_o` holds its updated value.
- `rise_o` and `fall_o` are never high in the same cycle. Consecutive pulses are at least DEBOUNCE cycles apart.
- `err_o` goes high the cycle after the conflict sample.
- No backpressure; the block accepts one sample per cycle unconditionally.

## Test plan
All scenarios use DEBOUNCE=3 and CNT_W=4.
- **Reset:** assert `rst_i` for 2 cycles with arbitrary inputs -> all outputs 0. Then 3 valid samples with `hi_gt_i`=1 -> `rise_o` pulses one cycle after the 3rd sample, `level_o`=1, `event_cnt_o`=1.
- **Aborted rise:** `hi_gt_i` = 1, 1, 0, 1, 1 on consecutive valid samples -> no `rise_o`, `level_o` stays 0 (run restarts at the 0 sample). A further `hi_gt_i`=1 -> rise.
- **Gaps:** qualifying samples separated by `valid_i`=0 gaps of 1-5 cycles -> rise after the 3rd valid sample regardless of gaps.
- **Fall:** from HIGH, `lo_lt_i` = 1, 1 then a band sample, then 1, 1, 1 -> a single `fall_o` after the last sample, `level_o`=0, `event_cnt_o` unchanged.
- **Saturation and clear:**
  - 16 full rise/fall cycles -> `event_cnt_o` saturates at 15.
  - `clear_i` asserted in the same cycle as a rise update -> `event_cnt_o`=0 next cycle, while `rise_o` still pulses.
- **Conflict:**
  - A valid sample with both flags 1 during RISING (`run`=2) -> `err_o`=1 next cycle, state held.
  - Next `hi_gt_i`=1 sample -> rise.
  - `clear_i` -> `err_o`=0.
